// File: rtl/button_conditioner.sv
// button_conditioner
//   Push-button front end. Each of NUM_BUTTONS trigger channels is
//   synchronised, debounced and turned into one-cycle trigger events
//   according to a per-channel mode. A separate reset-button channel uses
//   the same sync/debounce path and produces a stretched active-low system
//   reset.
//
//   Optional feature macro: BUTTON_CONDITIONER_EVENT_COUNT_EN
//     Adds a per-channel 8-bit saturating count of trigger_pulse assertions.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn_raw        raw active-high trigger buttons        [NUM_BUTTONS]
//   btn_reset_raw  raw active-high reset button
//   mode           per-channel mode, bits [2i+1:2i]       [2*NUM_BUTTONS]
//                    00 press, 01 release, 10 both edges, 11 press + auto-repeat
//   btn_level      debounced stable level                 [NUM_BUTTONS]
//   trigger_pulse  one-cycle event per channel mode       [NUM_BUTTONS]
//   sys_rst_n      stretched active-low system reset
//   clr_counts     (feature) zero all event counts
//   event_count    (feature) per-channel counts, 8 bits each [8*NUM_BUTTONS]

module button_conditioner #(
    parameter int NUM_BUTTONS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int RESET_HOLD      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_BUTTONS-1:0]   btn_raw,
    input  logic                     btn_reset_raw,
    input  logic [2*NUM_BUTTONS-1:0] mode,
    output logic [NUM_BUTTONS-1:0]   btn_level,
    output logic [NUM_BUTTONS-1:0]   trigger_pulse,
    output logic                     sys_rst_n
`ifdef BUTTON_CONDITIONER_EVENT_COUNT_EN
    ,
    input  logic                     clr_counts,
    output logic [8*NUM_BUTTONS-1:0] event_count
`endif
);

    // Channel NUM_BUTTONS of the sync/debounce arrays is the reset button.
    localparam int NCH    = NUM_BUTTONS + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX) + 1;
    localparam int RH_W   = $clog2(RESET_HOLD) + 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [RH_W-1:0] HOLD_LAST   = RH_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        RST_HOLD,    // counting down the stretch after release / power-up
        RST_ASSERT,  // debounced reset button is pressed
        RST_IDLE     // system reset released
    } rst_state_e;

    logic [NCH-1:0]         raw_all;
    logic [SYNC_STAGES-1:0] sync_q   [NCH];
    logic [SYNC_STAGES-1:0] sync_d   [NCH];
    logic [NCH-1:0]         stable_q;
    logic [NCH-1:0]         stable_d;
    logic [DB_W-1:0]        db_cnt_q [NCH];
    logic [DB_W-1:0]        db_cnt_d [NCH];

    logic [NUM_BUTTONS-1:0]   trig_q,       trig_d;
    logic [NUM_BUTTONS-1:0]   rep_active_q, rep_active_d;
    logic [NUM_BUTTONS-1:0]   rep_armed_q,  rep_armed_d;
    logic [RP_W-1:0]          rep_cnt_q [NUM_BUTTONS];
    logic [RP_W-1:0]          rep_cnt_d [NUM_BUTTONS];
    logic [2*NUM_BUTTONS-1:0] mode_q,       mode_d;

    rst_state_e      rst_state_q;
    logic [RH_W-1:0] hold_cnt_q;
    logic            sys_rst_n_q;

    assign raw_all = {btn_reset_raw, btn_raw};

    // Synchroniser shift and debounce counter for every channel.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_all[i]};
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i][SYNC_STAGES-1] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync_q[i][SYNC_STAGES-1];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Edge detection uses stable_d vs stable_q so the registered pulse lands
    // in the same cycle btn_level first shows the new value.
    always_comb begin
        logic       press;
        logic       rel;
        logic       mode_chg;
        logic [1:0] m;
        press        = 1'b0;
        rel          = 1'b0;
        mode_chg     = 1'b0;
        m            = 2'b00;
        mode_d       = mode;
        trig_d       = '0;
        rep_active_d = rep_active_q;
        rep_armed_d  = rep_armed_q;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            press    = stable_d[i] & ~stable_q[i];
            rel      = ~stable_d[i] & stable_q[i];
            m        = mode[2*i +: 2];
            mode_chg = (m != mode_q[2*i +: 2]);
            rep_cnt_d[i] = rep_cnt_q[i];

            case (m)
                2'b00:   trig_d[i] = press;
                2'b01:   trig_d[i] = rel;
                2'b10:   trig_d[i] = press | rel;
                default: trig_d[i] = press;
            endcase

            // Auto-repeat only runs for a press that happened in mode 11;
            // a mode change while held just stops it, emitting nothing.
            if (press) begin
                rep_cnt_d[i]    = '0;
                rep_armed_d[i]  = 1'b0;
                rep_active_d[i] = (m == 2'b11);
            end else if (rel || !stable_q[i] || mode_chg) begin
                rep_cnt_d[i]    = '0;
                rep_armed_d[i]  = 1'b0;
                rep_active_d[i] = 1'b0;
            end else if (rep_active_q[i]) begin
                if ((!rep_armed_q[i] && rep_cnt_q[i] == DELAY_LAST) ||
                    ( rep_armed_q[i] && rep_cnt_q[i] == PERIOD_LAST)) begin
                    trig_d[i]      = 1'b1;
                    rep_cnt_d[i]   = '0;
                    rep_armed_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + RP_W'(1);
                end
            end else begin
                rep_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                sync_q[i]   <= '0;
                db_cnt_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                rep_cnt_q[i] <= '0;
            end
            stable_q     <= '0;
            trig_q       <= '0;
            rep_active_q <= '0;
            rep_armed_q  <= '0;
            mode_q       <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                sync_q[i]   <= sync_d[i];
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
            stable_q     <= stable_d;
            trig_q       <= trig_d;
            rep_active_q <= rep_active_d;
            rep_armed_q  <= rep_armed_d;
            mode_q       <= mode_d;
        end
    end

    // Reset stretcher: low while the debounced reset button is held, then
    // RESET_HOLD further cycles. Power-up enters the hold state directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_state_q <= RST_HOLD;
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
        end else if (stable_q[NUM_BUTTONS]) begin
            rst_state_q <= RST_ASSERT;
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
        end else begin
            case (rst_state_q)
                RST_IDLE: begin
                    rst_state_q <= RST_IDLE;
                end
                default: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        rst_state_q <= RST_IDLE;
                        hold_cnt_q  <= '0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        rst_state_q <= RST_HOLD;
                        hold_cnt_q  <= hold_cnt_q + RH_W'(1);
                    end
                end
            endcase
        end
    end

    assign btn_level     = stable_q[NUM_BUTTONS-1:0];
    assign trigger_pulse = trig_q;
    assign sys_rst_n     = sys_rst_n_q;

`ifdef BUTTON_CONDITIONER_EVENT_COUNT_EN
    logic [8*NUM_BUTTONS-1:0] evt_q, evt_d;

    // Counts the registered pulse; clear wins over a pulse in the same cycle.
    always_comb begin
        evt_d = evt_q;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            if (clr_counts) begin
                evt_d[8*i +: 8] = '0;
            end else if (trig_q[i] && (evt_q[8*i +: 8] != 8'hFF)) begin
                evt_d[8*i +: 8] = evt_q[8*i +: 8] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign event_count = evt_q;
`endif

endmodule
